// File: rtl/sample_serializer.sv
// Buffers signed PCM samples in a small FIFO and streams each one, MSB first,
// on both channels of an I2S frame (64 bit slots, one-slot data delay).
module sample_serializer #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int BCLK_DIV     = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SAMPLE_WIDTH-1:0]       sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          dac_bclk,
    output logic                          dac_lrck,
    output logic                          dac_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    logic [DIV_W-1:0]        div_cnt;
    logic [5:0]              bit_cnt;
    logic [31:0]             frame_w;
    logic [SAMPLE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;

    logic        div_wrap;
    logic        fall_evt;
    logic        frame_load;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [5:0]  next_bit;
    logic [31:0] load_word;
    logic [31:0] next_w;
    logic [4:0]  slot_idx;
    logic        next_data;

    always_comb begin
        div_wrap     = (div_cnt == DIV_LAST);
        fall_evt     = div_wrap && dac_bclk;
        next_bit     = bit_cnt + 6'd1;
        frame_load   = fall_evt && (next_bit == 6'd1);
        fifo_empty   = (fifo_level == '0);
        sample_ready = (fifo_level < FULL_LEVEL);
        push         = sample_valid && sample_ready;
        pop          = frame_load && !fifo_empty;
        load_word    = fifo_empty ? 32'd0
                                  : (32'(fifo_mem[rd_ptr]) << (32 - SAMPLE_WIDTH));
        // Slot 1 must already emit the MSB of the word being loaded on this edge.
        next_w       = frame_load ? load_word : frame_w;
        // Slot s carries W[(32 - s) mod 32]; slot 0 therefore repeats the old LSB.
        slot_idx     = 5'd0 - next_bit[4:0];
        next_data    = next_w[slot_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            dac_bclk   <= 1'b0;
            bit_cnt    <= '0;
            dac_lrck   <= 1'b0;
            dac_data   <= 1'b0;
            frame_w    <= '0;
            underflow  <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            underflow <= 1'b0;

            if (div_wrap) begin
                div_cnt  <= '0;
                dac_bclk <= ~dac_bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fall_evt) begin
                bit_cnt  <= next_bit;
                dac_lrck <= next_bit[5];
                dac_data <= next_data;
                if (frame_load) begin
                    frame_w   <= load_word;
                    underflow <= fifo_empty;
                end
            end

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
        end
    end

    // NOTE: storage array has no reset; the cleared level/pointers make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sample_in;
    end

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: slot-accurate frame vectors plus
// hand-written fill, underflow, push/load race and mid-frame reset sequences.
module tb_sample_serializer;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        sample_ready, dac_bclk, dac_lrck, dac_data, underflow;
    logic [2:0]  fifo_level;

    logic [31:0] sample_in4;
    logic        sample_valid4;
    logic        sample_ready4, dac_bclk4, dac_lrck4, dac_data4, underflow4;
    logic [2:0]  fifo_level4;

    int edges;
    int checks;
    int errors;

    typedef struct {
        int   slot;
        logic lrck;
        logic data;
        logic uf;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sample_serializer #(.SAMPLE_WIDTH(32), .BCLK_DIV(D), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .dac_bclk(dac_bclk), .dac_lrck(dac_lrck),
        .dac_data(dac_data), .fifo_level(fifo_level), .underflow(underflow)
    );

    sample_serializer #(.SAMPLE_WIDTH(32), .BCLK_DIV(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .sample_in(sample_in4), .sample_valid(sample_valid4),
        .sample_ready(sample_ready4), .dac_bclk(dac_bclk4), .dac_lrck(dac_lrck4),
        .dac_data(dac_data4), .fifo_level(fifo_level4), .underflow(underflow4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        #1;
    endtask

    // Slot s is entered on edge 2*D*k after reset release, k mod 64 == s.
    task automatic wait_slot(input int s);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!((edges % (2 * D) == 0) && ((edges / (2 * D)) % 64 == s)) && n < 600);
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL wait_slot %0d: timed out", s);
        end
    endtask

    task automatic capture_bits(input int first, input logic [31:0] init, output logic [31:0] w);
        w = init;
        for (int s = first; s <= 32; s++) begin
            wait_slot(s);
            if (s == 1) check("load underflow", 32'(underflow), 32'd0);
            w[32 - s] = dac_data;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " bclk"},   32'(dac_bclk),     32'd0);
        check({tag, " lrck"},   32'(dac_lrck),     32'd0);
        check({tag, " data"},   32'(dac_data),     32'd0);
        check({tag, " uflow"},  32'(underflow),    32'd0);
        check({tag, " level"},  32'(fifo_level),   32'd0);
        check({tag, " ready"},  32'(sample_ready), 32'd1);
        check({tag, " bclk4"},  32'(dac_bclk4),    32'd0);
        check({tag, " lrck4"},  32'(dac_lrck4),    32'd0);
        check({tag, " data4"},  32'(dac_data4),    32'd0);
        check({tag, " ready4"}, 32'(sample_ready4), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pat;
        logic [31:0] words [5];
        logic [31:0] got;

        checks = 0;
        errors = 0;
        edges = 0;
        reset_n = 1'b0;
        sample_in = '0;
        sample_valid = 1'b0;
        sample_in4 = '0;
        sample_valid4 = 1'b0;

        // Reset state, then first bclk rise after BCLK_DIV cycles
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("dut4 bclk edge%0d", edges), 32'(dac_bclk4), 32'((edges / 4) % 2));
            check($sformatf("bclk edge%0d", edges), 32'(dac_bclk), 32'((edges / 2) % 2));
        end
        check("first frame underflow", 32'(underflow), 32'd1);
        check("first frame data", 32'(dac_data), 32'd0);
        check("first frame level", 32'(fifo_level), 32'd0);

        // Single word 0xA5000001 carried by the second frame
        sample_in = 32'hA500_0001;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("push level", 32'(fifo_level), 32'd1);
        check("underflow cleared", 32'(underflow), 32'd0);

        pat = 8'hA5;
        for (int i = 0; i < 8; i++) vecs.push_back('{i + 1, 1'b0, pat[7 - i], 1'b0});
        vecs.push_back('{9,  1'b0, 1'b0, 1'b0});
        vecs.push_back('{31, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++) vecs.push_back('{i + 33, 1'b1, pat[7 - i], 1'b0});
        vecs.push_back('{63, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0,  1'b0, 1'b1, 1'b0});
        vecs.push_back('{1,  1'b0, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            wait_slot(vecs[i].slot);
            check($sformatf("vec%0d slot%0d lrck", i, vecs[i].slot), 32'(dac_lrck), 32'(vecs[i].lrck));
            check($sformatf("vec%0d slot%0d data", i, vecs[i].slot), 32'(dac_data), 32'(vecs[i].data));
            check($sformatf("vec%0d slot%0d uflow", i, vecs[i].slot), 32'(underflow), 32'(vecs[i].uf));
            check($sformatf("vec%0d slot%0d bclk", i, vecs[i].slot), 32'(dac_bclk), 32'd0);
        end

        // Underflow pulse lasts one cycle and the frame is silent
        step();
        check("underflow one cycle", 32'(underflow), 32'd0);
        check("underflow level", 32'(fifo_level), 32'd0);
        wait_slot(32);
        check("underflow frame slot32 lrck", 32'(dac_lrck), 32'd1);
        check("underflow frame slot32 data", 32'(dac_data), 32'd0);

        // Fill with valid held high: fifth word waits for the next pop
        words[0] = 32'h1234_5678;
        words[1] = 32'h8000_0001;
        words[2] = 32'hFFFF_0000;
        words[3] = 32'h0F0F_5AA5;
        words[4] = 32'hDEAD_BEEF;
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_in = words[i];
            check($sformatf("fill ready %0d", i), 32'(sample_ready), 32'd1);
            step();
            check($sformatf("fill level %0d", i), 32'(fifo_level), 32'(i + 1));
        end
        sample_in = words[4];
        check("full ready", 32'(sample_ready), 32'd0);
        repeat (3) step();
        check("full level held", 32'(fifo_level), 32'd4);
        wait_slot(1);
        check("after pop level", 32'(fifo_level), 32'd3);
        check("after pop ready", 32'(sample_ready), 32'd1);
        check("after pop underflow", 32'(underflow), 32'd0);
        got = '0;
        got[31] = dac_data;
        step();
        sample_valid = 1'b0;
        check("fifth accepted level", 32'(fifo_level), 32'd4);
        capture_bits(2, got, got);
        check("word0 serialized", got, words[0]);
        for (int i = 1; i < 5; i++) begin
            capture_bits(1, 32'd0, got);
            check($sformatf("word%0d serialized", i), got, words[i]);
        end
        check("drained level", 32'(fifo_level), 32'd0);

        // Push into the empty FIFO on the exact load edge
        wait_slot(0);
        repeat (2 * D - 1) step();
        sample_in = 32'h8000_0000;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check("race underflow", 32'(underflow), 32'd1);
        check("race slot1 data", 32'(dac_data), 32'd0);
        check("race level", 32'(fifo_level), 32'd1);
        wait_slot(32);
        check("race frame slot32 data", 32'(dac_data), 32'd0);
        wait_slot(1);
        check("race next frame data", 32'(dac_data), 32'd1);
        check("race next frame underflow", 32'(underflow), 32'd0);
        check("race next frame level", 32'(fifo_level), 32'd0);

        // Reset in the right channel with three words queued
        sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_in = words[i + 1];
            step();
        end
        sample_valid = 1'b0;
        check("queued level", 32'(fifo_level), 32'd3);
        wait_slot(40);
        check("slot40 lrck", 32'(dac_lrck), 32'd1);
        step();
        step();
        check("slot40 bclk high", 32'(dac_bclk), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("midframe reset");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        edges = 0;
        wait_slot(1);
        check("post-reset underflow", 32'(underflow), 32'd1);
        check("post-reset data", 32'(dac_data), 32'd0);
        check("post-reset level", 32'(fifo_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
